value_entry_unit: RTL and testbench

- Button-side front end for the 4-bit value path. It is the producer of the working value that the initialization path clears.
- Takes raw push-button levels (initialize, increment, decrement, confirm). Each is synchronized, debounced and edge-detected.
- Maintains the working value and hands a confirmed value downstream over a valid/ready handshake.
- Sits between the board buttons and the value-consuming datapath.

---
 rtl/value_entry_unit.sv | 156 +++++++++++++++
 tb/tb_value_entry_unit.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/value_entry_unit.sv
// ============================================================================
// Module   : value_entry_unit
// Brief    : Debounced push-button entry of a working value, committed over a
//            valid/ready handshake. Define VALUE_ENTRY_SATURATE_EN to saturate.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module value_entry_unit #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             initialize_button,
    input  logic             inc_button,
    input  logic             dec_button,
    input  logic             confirm_button,
    output logic [WIDTH-1:0] current_value,
    output logic [WIDTH-1:0] commit_value,
    output logic             commit_valid,
    input  logic             commit_ready
);

    localparam int c_NUM_BTN  = 4;
    localparam int c_BTN_INIT = 0;
    localparam int c_BTN_INC  = 1;
    localparam int c_BTN_DEC  = 2;
    localparam int c_BTN_CONF = 3;
    localparam int c_CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [WIDTH-1:0]   c_ALL_ONES = '1;
    localparam logic [WIDTH-1:0]   c_ZERO     = '0;

    localparam logic [0:0] c_ST_EDIT   = 1'b0;
    localparam logic [0:0] c_ST_COMMIT = 1'b1;

    logic [c_NUM_BTN-1:0] w_raw;
    logic [c_NUM_BTN-1:0] w_pulse;

    assign w_raw = {confirm_button, dec_button, inc_button, initialize_button};

    // Each button: 2-flop synchronizer, stability counter, rising-edge pulse.
    for (genvar gi = 0; gi < c_NUM_BTN; gi++) begin : g_btn
        logic               r_sync1;
        logic               r_sync2;
        logic               r_deb;
        logic               r_deb_d;
        logic [c_CNT_W-1:0] r_cnt;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_sync1 <= 1'b0;
                r_sync2 <= 1'b0;
                r_deb   <= 1'b0;
                r_deb_d <= 1'b0;
                r_cnt   <= '0;
            end else begin
                r_sync1 <= w_raw[gi];
                r_sync2 <= r_sync1;
                r_deb_d <= r_deb;
                if (r_sync2 == r_deb) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_CNT_LAST) begin
                    r_deb <= r_sync2;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end

        assign w_pulse[gi] = r_deb & ~r_deb_d;
    end

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic [WIDTH-1:0] r_current_value;
    logic [WIDTH-1:0] r_commit_value;
    logic             r_commit_valid;
    logic [WIDTH-1:0] w_value_nxt;
    logic [WIDTH-1:0] w_commit_value_nxt;
    logic             w_commit_valid_nxt;
    logic [WIDTH-1:0] w_inc_value;
    logic [WIDTH-1:0] w_dec_value;
    logic             w_confirm_take;

`ifdef VALUE_ENTRY_SATURATE_EN
    assign w_inc_value = (r_current_value == c_ALL_ONES) ? c_ALL_ONES : r_current_value + 1'b1;
    assign w_dec_value = (r_current_value == c_ZERO)     ? c_ZERO     : r_current_value - 1'b1;
`else
    assign w_inc_value = r_current_value + 1'b1;
    assign w_dec_value = r_current_value - 1'b1;
`endif

    // A confirm only outranks inc/dec when it is actually accepted (EDIT).
    assign w_confirm_take = (r_state == c_ST_EDIT) && w_pulse[c_BTN_CONF];

    always_comb begin
        w_state_nxt        = r_state;
        w_value_nxt        = r_current_value;
        w_commit_value_nxt = r_commit_value;
        w_commit_valid_nxt = r_commit_valid;

        if (w_pulse[c_BTN_INIT]) begin
            w_value_nxt = c_ZERO;
        end else if (!w_confirm_take) begin
            if (w_pulse[c_BTN_INC] && !w_pulse[c_BTN_DEC]) begin
                w_value_nxt = w_inc_value;
            end else if (w_pulse[c_BTN_DEC] && !w_pulse[c_BTN_INC]) begin
                w_value_nxt = w_dec_value;
            end
        end

        case (r_state)
            c_ST_EDIT: begin
                if (w_confirm_take && !w_pulse[c_BTN_INIT]) begin
                    w_commit_value_nxt = r_current_value;
                    w_commit_valid_nxt = 1'b1;
                    w_state_nxt        = c_ST_COMMIT;
                end
            end
            c_ST_COMMIT: begin
                if (r_commit_valid && commit_ready) begin
                    w_commit_valid_nxt = 1'b0;
                    w_state_nxt        = c_ST_EDIT;
                end
            end
            default: begin
                w_commit_valid_nxt = 1'b0;
                w_state_nxt        = c_ST_EDIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= c_ST_EDIT;
            r_current_value <= c_ZERO;
            r_commit_value  <= c_ZERO;
            r_commit_valid  <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_current_value <= w_value_nxt;
            r_commit_value  <= w_commit_value_nxt;
            r_commit_valid  <= w_commit_valid_nxt;
        end
    end

    assign current_value = r_current_value;
    assign commit_value  = r_commit_value;
    assign commit_valid  = r_commit_valid;

endmodule

`default_nettype wire

// File: tb/tb_value_entry_unit.sv
// ============================================================================
// Module   : tb_value_entry_unit
// Brief    : Directed and randomized button-press bench for value_entry_unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_value_entry_unit;

    localparam int WIDTH = 4;
    localparam int DB    = 4;
    localparam int MAXV  = (1 << WIDTH) - 1;
    localparam int HOLD  = DB + 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             initialize_button;
    logic             inc_button;
    logic             dec_button;
    logic             confirm_button;
    logic [WIDTH-1:0] current_value;
    logic [WIDTH-1:0] commit_value;
    logic             commit_valid;
    logic             commit_ready;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_val  = 0;

    always #5 clk = ~clk;

    value_entry_unit #(
        .WIDTH           (WIDTH),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .initialize_button (initialize_button),
        .inc_button        (inc_button),
        .dec_button        (dec_button),
        .confirm_button    (confirm_button),
        .current_value     (current_value),
        .commit_value      (commit_value),
        .commit_valid      (commit_valid),
        .commit_ready      (commit_ready)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic int model_inc(input int v);
`ifdef VALUE_ENTRY_SATURATE_EN
        return (v == MAXV) ? v : v + 1;
`else
        return (v + 1) % (MAXV + 1);
`endif
    endfunction

    function automatic int model_dec(input int v);
`ifdef VALUE_ENTRY_SATURATE_EN
        return (v == 0) ? 0 : v - 1;
`else
        return (v + MAXV) % (MAXV + 1);
`endif
    endfunction

    // mask bits: {confirm, dec, inc, init}; clean press then clean release
    task automatic press(input logic [3:0] mask, input int hold);
        initialize_button = mask[0];
        inc_button        = mask[1];
        dec_button        = mask[2];
        confirm_button    = mask[3];
        step(hold);
        initialize_button = 1'b0;
        inc_button        = 1'b0;
        dec_button        = 1'b0;
        confirm_button    = 1'b0;
        step(hold);
    endtask

    initial begin
        rst = 1'b1;
        initialize_button = 1'b0;
        inc_button = 1'b0;
        dec_button = 1'b0;
        confirm_button = 1'b0;
        commit_ready = 1'b0;
        step(3);
        check("rst_current", current_value, 0);
        check("rst_commit", commit_value, 0);
        check("rst_valid", commit_valid, 0);
        rst = 1'b0;
        step(2);

        // Latency: update lands on edge 3+DB after the level is first sampled
        inc_button = 1'b1;
        step(DB + 2);
        check("lat_before", current_value, 0);
        step(1);
        check("lat_at_edge", current_value, 1);
        step(3);
        inc_button = 1'b0;
        step(10);
        check("lat_hold", current_value, 1);
        exp_val = 1;

        // Bounce shorter than the debounce window is ignored
        for (int i = 0; i < 10; i++) begin
            inc_button = ~inc_button;
            step(2);
        end
        inc_button = 1'b0;
        step(HOLD);
        check("bounce", current_value, exp_val);
        for (int i = 0; i < 3; i++) begin
            press(4'b0010, HOLD);
            exp_val = model_inc(exp_val);
        end
        check("clean3", current_value, exp_val);

        // Wrap / saturate
        press(4'b0001, HOLD);
        exp_val = 0;
        check("init", current_value, exp_val);
        for (int i = 0; i < MAXV; i++) begin
            press(4'b0010, HOLD);
            exp_val = model_inc(exp_val);
        end
        check("to_max", current_value, exp_val);
        press(4'b0010, HOLD);
        exp_val = model_inc(exp_val);
        check("inc_top", current_value, exp_val);
        press(4'b0001, HOLD);
        press(4'b0100, HOLD);
        exp_val = model_dec(0);
        check("dec_zero", current_value, exp_val);

        // Handshake with held commit
        press(4'b0001, HOLD);
        exp_val = 0;
        for (int i = 0; i < 5; i++) begin
            press(4'b0010, HOLD);
            exp_val = model_inc(exp_val);
        end
        press(4'b1000, HOLD);
        check("hs_valid", commit_valid, 1);
        check("hs_commit", commit_value, 5);
        for (int i = 0; i < 3; i++) begin
            press(4'b0010, HOLD);
            exp_val = model_inc(exp_val);
        end
        check("hs_cur", current_value, 8);
        check("hs_commit_held", commit_value, 5);
        press(4'b1000, HOLD);
        check("hs_conf_ignored", commit_value, 5);
        check("hs_still_valid", commit_valid, 1);
        commit_ready = 1'b1;
        step(1);
        commit_ready = 1'b0;
        check("hs_accept", commit_valid, 0);
        commit_ready = 1'b1;
        step(3);
        commit_ready = 1'b0;
        check("ready_in_edit", commit_valid, 0);

        // Ready already high: valid lasts exactly one cycle
        commit_ready = 1'b1;
        confirm_button = 1'b1;
        step(DB + 3);
        check("one_cyc_valid", commit_valid, 1);
        check("one_cyc_commit", commit_value, exp_val);
        step(1);
        check("one_cyc_drop", commit_valid, 0);
        confirm_button = 1'b0;
        commit_ready = 1'b0;
        step(HOLD);

        // Simultaneous presses
        press(4'b0001, HOLD);
        exp_val = 0;
        for (int i = 0; i < 9; i++) begin
            press(4'b0010, HOLD);
            exp_val = model_inc(exp_val);
        end
        press(4'b0110, HOLD);
        check("inc_dec_cancel", current_value, 9);
        press(4'b1001, HOLD);
        exp_val = 0;
        check("init_conf_val", current_value, 0);
        check("init_conf_nocommit", commit_valid, 0);

        // Reset during an offer with inc mid-debounce
        for (int i = 0; i < 3; i++) press(4'b0010, HOLD);
        press(4'b1000, HOLD);
        check("mid_valid", commit_valid, 1);
        inc_button = 1'b1;
        step(4);
        rst = 1'b1;
        inc_button = 1'b0;
        step(1);
        check("mid_rst_cur", current_value, 0);
        check("mid_rst_commit", commit_value, 0);
        check("mid_rst_valid", commit_valid, 0);
        rst = 1'b0;
        step(15);
        check("no_late_inc", current_value, 0);
        check("no_late_valid", commit_valid, 0);

        // Button held through reset counts as one fresh press
        rst = 1'b1;
        inc_button = 1'b1;
        step(3);
        rst = 1'b0;
        step(DB + 3);
        check("held_thru_rst", current_value, 1);
        inc_button = 1'b0;
        step(HOLD);
        exp_val = 1;

        // Randomized presses and bounces against the arithmetic model
        for (int i = 0; i < 40; i++) begin
            int op;
            int hold;
            op   = int'($urandom_range(0, 6));
            hold = DB + 3 + int'($urandom_range(0, 4));
            case (op)
                0, 1: begin press(4'b0010, hold); exp_val = model_inc(exp_val); end
                2, 3: begin press(4'b0100, hold); exp_val = model_dec(exp_val); end
                4:    begin press(4'b0001, hold); exp_val = 0; end
                default: begin
                    if (op == 5) inc_button = 1'b1;
                    else dec_button = 1'b1;
                    step(int'($urandom_range(1, DB - 1)));
                    inc_button = 1'b0;
                    dec_button = 1'b0;
                    step(HOLD);
                end
            endcase
            check("rand_val", current_value, exp_val);
        end
        check("rand_no_commit", commit_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
